// File: rtl/addsub_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arb_pkg
// Description : Shared constants for the add/sub arbiter: FSM encoding,
//               datapath width and adder operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_arb_pkg;

    localparam int DATA_W = 8;

    // FSM encoding, kept as plain constants for legacy tool compatibility
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Operation codes understood by the shared adder
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [DATA_W-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arbiter_if
// Description : Request/response handshake bundle between the client blocks
//               (master) and the add/sub arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    import addsub_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W*NREQ-1:0] req_a;
    logic [DATA_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]        req_op;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [DATA_W-1:0]      resp_sum;
    logic                   resp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_ovf
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches the request vector
//               from ptr upward (modulo NREQ) and returns a one-hot grant and
//               its encoded index. Pointer storage lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IDW-1:0]  ptr,
    input  wire logic            enable,
    output logic      [NREQ-1:0] grant,
    output logic      [IDW-1:0]  index
);

    int   pos;
    logic found;

    // First requester at or after ptr wins; nothing is granted when disabled
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (enable && !found && req[pos]) begin
                grant[pos] = 1'b1;
                index      = IDW'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arbiter
// Description : Shares one external 8-bit adder/subtractor among NREQ
//               requesters. Accepts one request per IDLE cycle in round-robin
//               order, holds the operands on the adder for SETTLE cycles,
//               captures sum/overflow and returns them on a held response.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2,
    parameter int IDW    = $clog2(NREQ)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    addsub_arbiter_if.slave        bus,
    output logic      [DATA_W-1:0] adder_a,
    output logic      [DATA_W-1:0] adder_b,
    output logic                   adder_op,
    input  wire logic [DATA_W-1:0] adder_sum,
    input  wire logic              adder_overflow,
    output logic      [15:0]       op_count
);

    localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDW-1:0]   LAST_ID     = IDW'(NREQ - 1);

    logic [1:0]        state;
    logic [IDW-1:0]    ptr;
    logic [CNT_W-1:0]  settle_cnt;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              opnd_op;
    logic [IDW-1:0]    id_q;
    logic [DATA_W-1:0] sum_q;
    logic              ovf_q;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              arb_en;
    logic              accept;

    // Arbitration only runs in IDLE and out of reset, so req_ready stays low
    // while rst_n is held
    assign arb_en = (state == ST_IDLE) && rst_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .enable (arb_en),
        .grant  (grant),
        .index  (grant_idx)
    );

    // Grant is only ever issued to a valid requester, so any grant is an accept
    assign accept         = |grant;
    assign bus.req_ready  = grant;
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_ovf   = ovf_q;

    // The adder always sees the operand registers; they move only on accept
    assign adder_a  = opnd_a;
    assign adder_b  = opnd_b;
    assign adder_op = opnd_op;

    // Control FSM: accept, settle the adder, then hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            settle_cnt <= '0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            opnd_op    <= OP_ADD;
            id_q       <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opnd_a     <= bus.req_a[grant_idx*DATA_W +: DATA_W];
                        opnd_b     <= bus.req_b[grant_idx*DATA_W +: DATA_W];
                        opnd_op    <= bus.req_op[grant_idx];
                        id_q       <= grant_idx;
                        ptr        <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (settle_cnt == '0) begin
                        sum_q <= adder_sum;
                        ovf_q <= adder_overflow;
                        state <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_arbiter
// Description : Self-checking bench for addsub_arbiter with a behavioural
//               adder, a round-robin/arithmetic reference model and a
//               response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;
    import addsub_arb_pkg::*;

    localparam int NREQ   = 4;
    localparam int SETTLE = 2;
    localparam int IDW    = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adder_a;
    logic [7:0]  adder_b;
    logic        adder_op;
    logic [7:0]  adder_sum;
    logic        adder_overflow;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;

    addsub_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    addsub_arbiter #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE),
        .IDW    (IDW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .adder_a        (adder_a),
        .adder_b        (adder_b),
        .adder_op       (adder_op),
        .adder_sum      (adder_sum),
        .adder_overflow (adder_overflow),
        .op_count       (op_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared adder that lives outside the arbiter
    assign adder_sum      = adder_op ? (adder_a - adder_b) : (adder_a + adder_b);
    assign adder_overflow = adder_op ?
        ((adder_a[7] != adder_b[7]) && (adder_sum[7] != adder_a[7])) :
        ((adder_a[7] == adder_b[7]) && (adder_sum[7] != adder_a[7]));

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic int rr_pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int ref_sum(int a, int b, int op);
        int r;
        r = op ? (a - b) : (a + b);
        return r & 255;
    endfunction

    function automatic int ref_ovf(int a, int b, int op);
        int sa;
        int sb;
        int r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        r  = op ? (sa - sb) : (sa + sb);
        return ((r > 127) || (r < -128)) ? 1 : 0;
    endfunction

    typedef struct {
        int id;
        int sum;
        int ovf;
        int acc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    bit   busy   = 0;
    int   mptr   = 0;
    int   mcount = 0;
    int   last_a = 0;
    int   last_b = 0;
    int   last_op = 0;

    // Monitor/scoreboard: predicts grants, pushes expected results, checks responses
    always @(negedge clk) begin
        exp_t            e;
        int              w;
        int              a;
        int              b;
        int              op;
        logic [NREQ-1:0] exp_ready;
        cyc++;
        if (!rst_n) begin
            q.delete();
            busy   = 0;
            mptr   = 0;
            mcount = 0;
            last_a = 0;
            last_b = 0;
            last_op = 0;
            chk("rst_req_ready", int'(bus.req_ready), 0);
            chk("rst_resp_valid", int'(bus.resp_valid), 0);
            chk("rst_op_count", int'(op_count), 0);
            chk("rst_adder_a", int'(adder_a), 0);
        end else begin
            chk("op_count", int'(op_count), mcount);
            chk("adder_a", int'(adder_a), last_a);
            chk("adder_b", int'(adder_b), last_b);
            chk("adder_op", int'(adder_op), last_op);
            w = busy ? -1 : rr_pick(bus.req_valid, mptr);
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            chk("req_ready", int'(bus.req_ready), int'(exp_ready));
            if (w >= 0) begin
                a  = int'(bus.req_a[w*8 +: 8]);
                b  = int'(bus.req_b[w*8 +: 8]);
                op = int'(bus.req_op[w]);
                e.id  = w;
                e.sum = ref_sum(a, b, op);
                e.ovf = ref_ovf(a, b, op);
                e.acc = cyc;
                q.push_back(e);
                mptr    = (w + 1) % NREQ;
                busy    = 1;
                last_a  = a;
                last_b  = b;
                last_op = op;
            end
            if (q.size() > 0) begin
                if (cyc < q[0].acc + SETTLE + 1) begin
                    chk("resp_early", int'(bus.resp_valid), 0);
                end else begin
                    chk("resp_valid", int'(bus.resp_valid), 1);
                    if (bus.resp_valid) begin
                        chk("resp_id", int'(bus.resp_id), q[0].id);
                        chk("resp_sum", int'(bus.resp_sum), q[0].sum);
                        chk("resp_ovf", int'(bus.resp_ovf), q[0].ovf);
                        if (bus.resp_ready) begin
                            void'(q.pop_front());
                            busy   = 0;
                            mcount = (mcount + 1) & 16'hFFFF;
                        end
                    end
                end
            end else begin
                chk("resp_idle", int'(bus.resp_valid), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [NREQ-1:0] last_acc;
    bit              resp_seen;
    int              seen_id;
    int              seen_sum;
    int              seen_ovf;
    int              order[$];

    // One clock: sample at the falling edge, then retire accepted requests
    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc       = bus.req_valid & bus.req_ready;
        resp_seen = bus.resp_valid;
        seen_id   = int'(bus.resp_id);
        seen_sum  = int'(bus.resp_sum);
        seen_ovf  = int'(bus.resp_ovf);
        @(posedge clk);
        #2;
        bus.req_valid = bus.req_valid & ~acc;
        last_acc      = acc;
    endtask

    task automatic present(int r, logic [7:0] a, logic [7:0] b, logic op);
        bus.req_a[r*8 +: 8] = a;
        bus.req_b[r*8 +: 8] = b;
        bus.req_op[r]       = op;
        bus.req_valid[r]    = 1'b1;
    endtask

    task automatic wait_resp(string tag, int id, int sum, int ovf);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_seen && n < 100);
        if (!resp_seen) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_id"}, seen_id, id);
            chk({tag, "_sum"}, seen_sum, sum);
            chk({tag, "_ovf"}, seen_ovf, ovf);
        end
    endtask

    task automatic do_reset(bit check_async);
        rst_n = 1'b0;
        #1;
        if (check_async) begin
            chk("async_resp_valid", int'(bus.resp_valid), 0);
            chk("async_op_count", int'(op_count), 0);
            chk("async_adder_a", int'(adder_a), 0);
            chk("async_adder_b", int'(adder_b), 0);
            chk("async_adder_op", int'(adder_op), 0);
            chk("async_resp_sum", int'(bus.resp_sum), 0);
            chk("async_resp_id", int'(bus.resp_id), 0);
            chk("async_req_ready", int'(bus.req_ready), 0);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        last_acc = '0;
    endtask

    initial begin
        int n;
        int idx;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 1'b1;
        last_acc       = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed arithmetic cases
        present(0, 8'd13, 8'd12, 1'b0);
        wait_resp("add_13_12", 0, 8'h19, 0);
        chk("op_count_first", int'(op_count), 1);
        present(2, 8'd13, 8'hF4, 1'b1);
        wait_resp("sub_13_m12", 2, 8'h19, 0);
        present(2, 8'hF3, 8'hF4, 1'b0);
        wait_resp("add_m13_m12", 2, 8'hE7, 0);
        present(1, 8'd127, 8'd127, 1'b0);
        wait_resp("ovf_pos", 1, 8'hFE, 1);
        present(3, 8'h81, 8'h81, 1'b0);
        wait_resp("ovf_neg", 3, 8'h02, 1);

        // Response held while the consumer stalls
        bus.resp_ready = 1'b0;
        present(0, 8'h40, 8'h50, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_seen && n < 50);
        chk("hold_first_valid", int'(resp_seen), 1);
        present(1, 8'd5, 8'd6, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", int'(resp_seen), 1);
            chk("hold_sum", seen_sum, 8'hF0);
            chk("hold_id", seen_id, 0);
            chk("hold_req_ready", int'(bus.req_ready), 0);
        end
        bus.resp_ready = 1'b1;
        tick();
        chk("hold_op_count", int'(op_count), 6);
        wait_resp("after_hold", 1, 8'd11, 0);

        // Reset while the adder is settling drops the operation
        present(3, 8'd1, 8'd2, 1'b0);
        tick();
        chk("exec_accepted", int'(last_acc), 8);
        do_reset(1'b1);
        repeat (4) tick();
        chk("post_reset_op_count", int'(op_count), 0);
        present(3, 8'd1, 8'd2, 1'b0);
        wait_resp("post_reset", 3, 8'd3, 0);
        chk("post_reset_count1", int'(op_count), 1);

        // All requesters pending from reset: strict rotation expected
        for (int r = 0; r < NREQ; r++) present(r, 8'($urandom), 8'($urandom), 1'($urandom));
        do_reset(1'b0);
        n = 0;
        while (order.size() < 5 && n < 200) begin
            tick();
            if (last_acc != '0) begin
                idx = 0;
                for (int r = 0; r < NREQ; r++) if (last_acc[r]) idx = r;
                order.push_back(idx);
                present(idx, 8'($urandom), 8'($urandom), 1'($urandom));
            end
            n++;
        end
        chk("rr_grants", order.size(), 5);
        for (int k = 0; k < order.size(); k++) chk("rr_order", order[k], k % NREQ);

        // Randomized traffic with consumer back-pressure
        for (int c = 0; c < 800; c++) begin
            tick();
            bus.resp_ready = ($urandom_range(3) != 0);
            for (int r = 0; r < NREQ; r++) begin
                if (!bus.req_valid[r] && $urandom_range(2) == 0)
                    present(r, 8'($urandom), 8'($urandom), 1'($urandom));
                else if (bus.req_valid[r] && $urandom_range(23) == 0)
                    bus.req_valid[r] = 1'b0;
            end
        end

        // Drain
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        repeat (20) tick();
        chk("drain_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
